// File: rtl/core_struct_pkg.sv
// Shared core types: fetch FSM states, IF/ID pipeline slot and the canonical NOP encoding.
package core_struct;

   localparam int unsigned CORE_XLEN = 64;
   localparam int unsigned CORE_ILEN = 32;

   // addi x0,x0,0
   localparam logic [CORE_ILEN-1:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic                 valid;
      logic [CORE_XLEN-1:0] pc;
      logic [CORE_ILEN-1:0] inst;
   } if_id_t;

endpackage

// File: rtl/if_id_fetch_stage.sv
// Fetch stage with IF/ID register: owns the PC, issues one imem request at a time,
// absorbs load-use stalls through a one-entry hold buffer and drops stale responses after a redirect.
module if_id_fetch_stage
   import core_struct::*;
#(
   parameter int unsigned            XLEN     = CORE_XLEN,
   parameter int unsigned            ILEN     = CORE_ILEN,
   parameter logic [XLEN-1:0]        RESET_PC = 64'h0,
   parameter logic [ILEN-1:0]        NOP_INST = core_struct::NOP_INST
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            stall,
   input  logic            flush,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [ILEN-1:0] id_inst
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

   fetch_state_t    state_r,    state_s;
   logic [XLEN-1:0] pc_r,       pc_s;
   logic [XLEN-1:0] req_addr_r, req_addr_s;
   logic [ILEN-1:0] hold_buf_r, hold_buf_s;
   if_id_t          if_id_r,    if_id_s;

   assign imem_req  = rstn && (state_r != HOLD);
   assign imem_addr = req_addr_r;
   assign id_valid  = if_id_r.valid;
   assign id_pc     = if_id_r.pc;
   assign id_inst   = if_id_r.inst;

   // Next-state, PC, hold buffer and IF/ID slot; priority is flush > stall > ack
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      req_addr_s = req_addr_r;
      hold_buf_s = hold_buf_r;
      if_id_s    = if_id_r;
      case (state_r)
         FETCH: begin
            if (flush) begin
               if_id_s.valid = 1'b0;
               if_id_s.inst  = NOP_INST;
               pc_s          = redirect_pc;
               // Without an ack the old request is still in flight, so its address must stay put
               if (imem_ack) begin
                  req_addr_s = redirect_pc;
               end else begin
                  state_s = DROP;
               end
            end else if (stall) begin
               if (imem_ack) begin
                  hold_buf_s = imem_rdata;
                  state_s    = HOLD;
               end else begin
                  hold_buf_s = hold_buf_r;
               end
            end else if (imem_ack) begin
               if_id_s    = '{valid: 1'b1, pc: pc_r, inst: imem_rdata};
               pc_s       = pc_r + PC_STEP;
               req_addr_s = pc_r + PC_STEP;
            end else begin
               if_id_s.valid = 1'b0;
               if_id_s.inst  = NOP_INST;
            end
         end
         HOLD: begin
            if (flush) begin
               if_id_s.valid = 1'b0;
               if_id_s.inst  = NOP_INST;
               pc_s          = redirect_pc;
               req_addr_s    = redirect_pc;
               state_s       = FETCH;
            end else if (!stall) begin
               if_id_s    = '{valid: 1'b1, pc: pc_r, inst: hold_buf_r};
               pc_s       = pc_r + PC_STEP;
               req_addr_s = pc_r + PC_STEP;
               state_s    = FETCH;
            end else begin
               state_s = HOLD;
            end
         end
         DROP: begin
            if_id_s.valid = 1'b0;
            if_id_s.inst  = NOP_INST;
            if (flush) begin
               pc_s = redirect_pc;
            end else begin
               pc_s = pc_r;
            end
            if (imem_ack) begin
               req_addr_s = pc_s;
               state_s    = FETCH;
            end else begin
               state_s = DROP;
            end
         end
         default: begin
            state_s = FETCH;
         end
      endcase
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r    <= FETCH;
         pc_r       <= RESET_PC;
         req_addr_r <= RESET_PC;
         hold_buf_r <= NOP_INST;
         if_id_r    <= '{valid: 1'b0, pc: {XLEN{1'b0}}, inst: NOP_INST};
      end else begin
         state_r    <= state_s;
         pc_r       <= pc_s;
         req_addr_r <= req_addr_s;
         hold_buf_r <= hold_buf_s;
         if_id_r    <= if_id_s;
      end
   end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for the fetch stage: imem returns 0xA500_0000 ^ addr[31:0] so every expected
// instruction is a hand-written constant tied to its PC.
module tb_if_id_fetch_stage;
   import core_struct::*;

   logic        clk = 1'b0;
   logic        rstn;
   logic        stall;
   logic        flush;
   logic [63:0] redirect_pc;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [63:0] id_pc;
   logic [31:0] id_inst;

   int checks_cnt = 0;
   int errors_cnt = 0;

   always #5 clk = ~clk;

   assign imem_rdata = 32'hA500_0000 ^ imem_addr[31:0];

   if_id_fetch_stage dut (
      .clk         (clk),
      .rstn        (rstn),
      .stall       (stall),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .id_valid    (id_valid),
      .id_pc       (id_pc),
      .id_inst     (id_inst)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_id(input string tag, input logic v, input logic [63:0] pc, input logic [31:0] inst);
      check_eq({tag, ".valid"}, {63'd0, id_valid}, {63'd0, v});
      check_eq({tag, ".pc"}, id_pc, pc);
      check_eq({tag, ".inst"}, {32'd0, id_inst}, {32'd0, inst});
   endtask

   initial begin
      rstn = 1'b0; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0; redirect_pc = 64'h0;
      #2;
      // 1: reset then ack every cycle
      tick();
      check_id("rst", 1'b0, 64'h0, 32'h0000_0013);
      check_eq("rst.req", {63'd0, imem_req}, 64'd0);
      check_eq("rst.addr", imem_addr, 64'h0);
      rstn = 1'b1;
      #1;
      check_eq("t1.req", {63'd0, imem_req}, 64'd1);
      imem_ack = 1'b1;
      tick();
      check_id("t1.0", 1'b1, 64'h0, 32'hA500_0000);
      check_eq("t1.addr4", imem_addr, 64'h4);
      tick();
      check_id("t1.4", 1'b1, 64'h4, 32'hA500_0004);
      tick();
      check_id("t1.8", 1'b1, 64'h8, 32'hA500_0008);
      check_eq("t1.addrC", imem_addr, 64'hC);

      // 2: stall for three cycles, ack only in the first
      stall = 1'b1;
      tick();
      check_id("t2.s1", 1'b1, 64'h8, 32'hA500_0008);
      check_eq("t2.req_hold", {63'd0, imem_req}, 64'd0);
      imem_ack = 1'b0;
      tick();
      check_id("t2.s2", 1'b1, 64'h8, 32'hA500_0008);
      tick();
      check_id("t2.s3", 1'b1, 64'h8, 32'hA500_0008);
      check_eq("t2.req_s3", {63'd0, imem_req}, 64'd0);
      stall = 1'b0;
      tick();
      check_id("t2.C", 1'b1, 64'hC, 32'hA500_000C);
      check_eq("t2.req_rel", {63'd0, imem_req}, 64'd1);
      check_eq("t2.addr10", imem_addr, 64'h10);
      imem_ack = 1'b1;
      tick();
      check_id("t2.10", 1'b1, 64'h10, 32'hA500_0010);

      // 3: flush together with ack
      flush = 1'b1; redirect_pc = 64'h100;
      tick();
      check_id("t3.kill", 1'b0, 64'h10, 32'h0000_0013);
      check_eq("t3.addr", imem_addr, 64'h100);
      flush = 1'b0;
      tick();
      check_id("t3.100", 1'b1, 64'h100, 32'hA500_0100);
      check_eq("t3.addr104", imem_addr, 64'h104);

      // 4: flush while ack is late by two cycles
      imem_ack = 1'b0; flush = 1'b1; redirect_pc = 64'h200;
      tick();
      check_eq("t4.v0", {63'd0, id_valid}, 64'd0);
      check_eq("t4.addr_held0", imem_addr, 64'h104);
      check_eq("t4.req", {63'd0, imem_req}, 64'd1);
      flush = 1'b0;
      tick();
      check_eq("t4.v1", {63'd0, id_valid}, 64'd0);
      check_eq("t4.addr_held1", imem_addr, 64'h104);
      imem_ack = 1'b1;
      tick();
      check_eq("t4.v2", {63'd0, id_valid}, 64'd0);
      check_eq("t4.addr200", imem_addr, 64'h200);
      tick();
      check_id("t4.200", 1'b1, 64'h200, 32'hA500_0200);

      // 5: flush and stall together in HOLD
      stall = 1'b1;
      tick();
      check_eq("t5.req_hold", {63'd0, imem_req}, 64'd0);
      check_id("t5.frozen", 1'b1, 64'h200, 32'hA500_0200);
      imem_ack = 1'b0; flush = 1'b1; redirect_pc = 64'h300;
      tick();
      check_eq("t5.v0", {63'd0, id_valid}, 64'd0);
      check_eq("t5.addr300", imem_addr, 64'h300);
      check_eq("t5.req", {63'd0, imem_req}, 64'd1);
      flush = 1'b0; stall = 1'b0; imem_ack = 1'b1;
      tick();
      check_id("t5.300", 1'b1, 64'h300, 32'hA500_0300);

      // 6: reset in the middle of DROP, with a late ack during reset
      imem_ack = 1'b0; flush = 1'b1; redirect_pc = 64'h400;
      tick();
      check_eq("t6.drop_addr", imem_addr, 64'h304);
      flush = 1'b0; rstn = 1'b0; imem_ack = 1'b1;
      tick();
      check_id("t6.rst", 1'b0, 64'h0, 32'h0000_0013);
      check_eq("t6.req", {63'd0, imem_req}, 64'd0);
      check_eq("t6.addr", imem_addr, 64'h0);
      rstn = 1'b1; imem_ack = 1'b0;
      tick();
      check_eq("t6.v", {63'd0, id_valid}, 64'd0);
      check_eq("t6.addr0", imem_addr, 64'h0);
      imem_ack = 1'b1;
      tick();
      check_id("t6.0", 1'b1, 64'h0, 32'hA500_0000);

      // PC wrap and unaligned redirect pass-through
      flush = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      check_eq("wrap.addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      flush = 1'b0;
      tick();
      check_id("wrap.id", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h5AFF_FFFC);
      check_eq("wrap.next", imem_addr, 64'h0);
      flush = 1'b1; redirect_pc = 64'h502;
      tick();
      check_eq("unal.addr", imem_addr, 64'h502);
      flush = 1'b0;
      tick();
      check_id("unal.id", 1'b1, 64'h502, 32'hA500_0502);
      check_eq("unal.next", imem_addr, 64'h506);

      $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
